// File: rtl/execute_issue_ctrl.sv
// ============================================================================
// Module      : execute_issue_ctrl
// Description : Execute-stage handshake controller. Passes single-cycle ops
//               straight through and holds the stage for mul/div latency.
//               Optional macro EXEC_DIV0_FAST_EN: divide-by-zero completes
//               as a single-cycle op.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_issue_ctrl #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             decode_vaild_i,
    input  logic             DD_mul_i,
    input  logic             DD_div_i,
    input  logic [XLEN-1:0]  DD_rs2_data_i,
    input  logic             flush_i,
    input  logic             memory_allow_in_i,
    output logic             execute_ready_o,
    output logic             execute_allow_in_o,
    output logic             execute_vaild_o,
    output logic             unit_start_o,
    output logic             exec_busy_o,
    output logic [CNT_W-1:0] exec_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_div0;
    logic             w_is_div;
    logic             w_is_mul;
    logic             w_multi;
    logic [CNT_W-1:0] w_load;
    logic             w_ready;
    logic             w_start;

`ifdef EXEC_DIV0_FAST_EN
    assign w_div0 = (DD_rs2_data_i == '0);
`else
    logic w_unused_rs2;
    assign w_div0       = 1'b0;
    assign w_unused_rs2 = ^DD_rs2_data_i;
`endif

    // Divide wins over multiply when both flags are set.
    assign w_is_div = DD_div_i & ~w_div0;
    assign w_is_mul = ~DD_div_i & DD_mul_i;
    assign w_multi  = w_is_div | w_is_mul;
    assign w_load   = w_is_div ? c_DIV_LOAD : c_MUL_LOAD;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready     = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (decode_vaild_i && w_multi) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = w_load;
                end else begin
                    w_ready = decode_vaild_i;
                end
            end
            S_RUN: begin
                w_ready = (r_cnt == '0);
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end else if (memory_allow_in_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_ready   = 1'b1;
                w_cnt_nxt = '0;
                if (memory_allow_in_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // Flush discards any in-flight unit result.
        if (flush_i) begin
            w_start     = 1'b0;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end
        if (!rst_n) begin
            w_ready = 1'b0;
            w_start = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign execute_ready_o    = w_ready;
    assign unit_start_o       = w_start;
    assign execute_allow_in_o = ~rst_n | ~decode_vaild_i | (w_ready & memory_allow_in_i) | flush_i;
    assign execute_vaild_o    = rst_n & decode_vaild_i & w_ready & memory_allow_in_i & ~flush_i;
    assign exec_busy_o        = rst_n & (r_state != S_IDLE);
    assign exec_cnt_o         = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_execute_issue_ctrl.sv
// ============================================================================
// Module      : tb_execute_issue_ctrl
// Description : Table vectors, directed multi-cycle sequences and a random
//               run against a cycle-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_issue_ctrl;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 33;
    localparam int CNT_W   = 6;
`ifdef EXEC_DIV0_FAST_EN
    localparam bit FAST_DIV0 = 1'b1;
`else
    localparam bit FAST_DIV0 = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_n;
    logic             decode_vaild_i;
    logic             DD_mul_i;
    logic             DD_div_i;
    logic [XLEN-1:0]  DD_rs2_data_i;
    logic             flush_i;
    logic             memory_allow_in_i;
    logic             execute_ready_o;
    logic             execute_allow_in_o;
    logic             execute_vaild_o;
    logic             unit_start_o;
    logic             exec_busy_o;
    logic [CNT_W-1:0] exec_cnt_o;

    always #5 clk_i = ~clk_i;

    execute_issue_ctrl #(
        .XLEN(XLEN), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .decode_vaild_i(decode_vaild_i),
        .DD_mul_i(DD_mul_i),
        .DD_div_i(DD_div_i),
        .DD_rs2_data_i(DD_rs2_data_i),
        .flush_i(flush_i),
        .memory_allow_in_i(memory_allow_in_i),
        .execute_ready_o(execute_ready_o),
        .execute_allow_in_o(execute_allow_in_o),
        .execute_vaild_o(execute_vaild_o),
        .unit_start_o(unit_start_o),
        .exec_busy_o(exec_busy_o),
        .exec_cnt_o(exec_cnt_o)
    );

    typedef struct packed {
        logic dv, mul, div, flush, mem;
        logic ready, allow, vaild, start;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled 4 later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_in(input logic dv, input logic mul, input logic div,
                          input logic fl, input logic mem, input logic [XLEN-1:0] rs2);
        decode_vaild_i    = dv;
        DD_mul_i          = mul;
        DD_div_i          = div;
        flush_i           = fl;
        memory_allow_in_i = mem;
        DD_rs2_data_i     = rs2;
    endtask

    vec_t tbl [9];

    // Reference model: remembers the cycle an op was issued and derives
    // readiness and the remaining count from elapsed cycles.
    bit  m_act;
    int  m_issue;
    int  m_lat;
    int  cyc;

    initial begin
        rst_n = 1'b0;
        set_in(1, 1, 0, 0, 1, 32'd5);
        tick();
        #4;
        chk("rst_ready", 32'(execute_ready_o), 0);
        chk("rst_allow", 32'(execute_allow_in_o), 1);
        chk("rst_vaild", 32'(execute_vaild_o), 0);
        chk("rst_start", 32'(unit_start_o), 0);
        chk("rst_busy",  32'(exec_busy_o), 0);
        chk("rst_cnt",   32'(exec_cnt_o), 0);
        tick();
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 1, 32'd5);
        tick();

        // dv mul div flush mem | ready allow vaild start
        tbl[0] = vec_t'(9'b1_0_0_0_1_1_1_1_0);
        tbl[1] = vec_t'(9'b1_0_0_0_0_1_0_0_0);
        tbl[2] = vec_t'(9'b0_1_0_0_1_0_1_0_0);
        tbl[3] = vec_t'(9'b1_1_0_0_1_0_0_0_1);
        tbl[4] = vec_t'(9'b1_0_1_0_1_0_0_0_1);
        tbl[5] = vec_t'(9'b1_1_1_0_1_0_0_0_1);
        tbl[6] = vec_t'(9'b1_1_0_1_1_0_1_0_0);
        tbl[7] = vec_t'(9'b1_0_0_1_1_1_1_0_0);
        tbl[8] = vec_t'(9'b0_0_0_0_0_0_1_0_0);
        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].dv, tbl[i].mul, tbl[i].div, tbl[i].flush, tbl[i].mem, 32'd5);
            #4;
            chk($sformatf("tbl%0d_ready", i), 32'(execute_ready_o), 32'(tbl[i].ready));
            chk($sformatf("tbl%0d_allow", i), 32'(execute_allow_in_o), 32'(tbl[i].allow));
            chk($sformatf("tbl%0d_vaild", i), 32'(execute_vaild_o), 32'(tbl[i].vaild));
            chk($sformatf("tbl%0d_start", i), 32'(unit_start_o), 32'(tbl[i].start));
            chk($sformatf("tbl%0d_busy", i),  32'(exec_busy_o), 0);
            flush_i = 1'b1;
            tick();
        end

        // MUL issued at T: held until T+3, idle again at T+4.
        set_in(1, 1, 0, 0, 1, 32'd5);
        #4;
        chk("mul_T_start", 32'(unit_start_o), 1);
        chk("mul_T_allow", 32'(execute_allow_in_o), 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            #4;
            chk($sformatf("mul_T%0d_start", k), 32'(unit_start_o), 0);
            chk($sformatf("mul_T%0d_cnt", k), 32'(exec_cnt_o), 32'(3 - k));
            chk($sformatf("mul_T%0d_ready", k), 32'(execute_ready_o), (k == 3) ? 1 : 0);
            chk($sformatf("mul_T%0d_allow", k), 32'(execute_allow_in_o), (k == 3) ? 1 : 0);
            chk($sformatf("mul_T%0d_vaild", k), 32'(execute_vaild_o), (k == 3) ? 1 : 0);
        end
        tick();
        set_in(0, 0, 0, 0, 1, 32'd5);
        #4;
        chk("mul_T4_busy", 32'(exec_busy_o), 0);

        // DIV with memory stalled at completion: DONE then release.
        tick();
        set_in(1, 0, 1, 0, 0, 32'd7);
        for (int k = 0; k < 32; k++) tick();
        #4;
        chk("div_T32_ready", 32'(execute_ready_o), 0);
        chk("div_T32_cnt",   32'(exec_cnt_o), 1);
        tick();
        #4;
        chk("div_T33_ready", 32'(execute_ready_o), 1);
        chk("div_T33_allow", 32'(execute_allow_in_o), 0);
        chk("div_T33_vaild", 32'(execute_vaild_o), 0);
        tick();
        #4;
        chk("div_T34_ready", 32'(execute_ready_o), 1);
        chk("div_T34_allow", 32'(execute_allow_in_o), 0);
        chk("div_T34_busy",  32'(exec_busy_o), 1);
        chk("div_T34_cnt",   32'(exec_cnt_o), 0);
        tick();
        memory_allow_in_i = 1'b1;
        #4;
        chk("div_T35_vaild", 32'(execute_vaild_o), 1);
        chk("div_T35_allow", 32'(execute_allow_in_o), 1);
        tick();
        decode_vaild_i = 1'b0;
        #4;
        chk("div_T36_busy", 32'(exec_busy_o), 0);

        // DIV flushed mid-flight.
        tick();
        set_in(1, 0, 1, 0, 1, 32'd7);
        for (int k = 0; k < 5; k++) tick();
        flush_i = 1'b1;
        #4;
        chk("flush_vaild", 32'(execute_vaild_o), 0);
        chk("flush_allow", 32'(execute_allow_in_o), 1);
        chk("flush_start", 32'(unit_start_o), 0);
        tick();
        set_in(0, 0, 0, 0, 1, 32'd7);
        #4;
        chk("flush_T6_busy", 32'(exec_busy_o), 0);
        chk("flush_T6_cnt",  32'(exec_cnt_o), 0);

        // Reset asserted during RUN.
        tick();
        set_in(1, 0, 1, 0, 1, 32'd7);
        for (int k = 0; k < 10; k++) tick();
        #4;
        chk("rrun_T10_busy", 32'(exec_busy_o), 1);
        rst_n = 1'b0;
        #1;
        chk("rrun_allow", 32'(execute_allow_in_o), 1);
        chk("rrun_ready", 32'(execute_ready_o), 0);
        tick();
        #4;
        chk("rrun_T11_cnt",   32'(exec_cnt_o), 0);
        chk("rrun_T11_allow", 32'(execute_allow_in_o), 1);
        tick();
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 1, 32'd7);
        tick();
        #4;
        chk("rrun_after_busy", 32'(exec_busy_o), 0);

        // Divide by zero.
        tick();
        set_in(1, 0, 1, 0, 1, 32'd0);
        #4;
        if (FAST_DIV0) begin
            chk("div0_ready", 32'(execute_ready_o), 1);
            chk("div0_start", 32'(unit_start_o), 0);
            chk("div0_vaild", 32'(execute_vaild_o), 1);
            tick();
            decode_vaild_i = 1'b0;
        end else begin
            chk("div0_ready", 32'(execute_ready_o), 0);
            chk("div0_start", 32'(unit_start_o), 1);
            for (int k = 0; k < DIV_LAT; k++) tick();
            #4;
            chk("div0_T33_ready", 32'(execute_ready_o), 1);
            tick();
            decode_vaild_i = 1'b0;
        end
        #4;
        chk("div0_end_busy", 32'(exec_busy_o), 0);

        // Random run against the reference model.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        m_act   = 1'b0;
        m_issue = 0;
        m_lat   = 0;
        cyc     = 0;
        for (int n = 0; n < 2000; n++) begin
            logic dv, mul, div, fl, mem, rst;
            logic [XLEN-1:0] rs2;
            bit   multi, e_ready, e_start;
            int   e_cnt, lat;
            dv  = ($urandom % 8) != 0;
            mul = ($urandom % 3) == 0;
            div = ($urandom % 5) == 0;
            fl  = ($urandom % 20) == 0;
            mem = ($urandom % 4) != 0;
            rst = ($urandom % 60) == 0;
            rs2 = (($urandom % 4) == 0) ? '0 : XLEN'($urandom);
            set_in(dv, mul, div, fl, mem, rs2);
            rst_n = ~rst;
            #4;
            multi = div ? !(FAST_DIV0 && rs2 == 0) : mul;
            lat   = div ? DIV_LAT : MUL_LAT;
            if (m_act) begin
                e_ready = (cyc - m_issue) >= m_lat;
                e_start = 1'b0;
                e_cnt   = e_ready ? 0 : (m_issue + m_lat - cyc);
            end else begin
                e_ready = dv && !multi;
                e_start = dv && multi && !fl;
                e_cnt   = 0;
            end
            if (rst) begin
                e_ready = 1'b0;
                e_start = 1'b0;
            end
            chk("rnd_ready", 32'(execute_ready_o), 32'(e_ready));
            chk("rnd_start", 32'(unit_start_o), 32'(e_start));
            chk("rnd_allow", 32'(execute_allow_in_o), 32'(rst || !dv || (e_ready && mem) || fl));
            chk("rnd_vaild", 32'(execute_vaild_o), 32'(!rst && dv && e_ready && mem && !fl));
            chk("rnd_busy",  32'(exec_busy_o), 32'(!rst && m_act));
            chk("rnd_cnt",   32'(exec_cnt_o), 32'(e_cnt));
            if (rst || fl) begin
                m_act = 1'b0;
            end else if (!m_act) begin
                if (dv && multi) begin
                    m_act   = 1'b1;
                    m_issue = cyc;
                    m_lat   = lat;
                end
            end else if (e_ready && mem) begin
                m_act = 1'b0;
            end
            tick();
            cyc++;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
